// File: rtl/button_event_decoder_if.sv
// Button-level in, UI events out: one bundle per button between the debouncer and the mode FSM.
interface button_event_decoder_if;
  logic i_btnsig;
  logic o_press;
  logic o_release;
  logic o_short_press;
  logic o_long_press;
  logic o_repeat;
  logic o_held;

  modport master (
    output i_btnsig,
    input  o_press, o_release, o_short_press, o_long_press, o_repeat, o_held
  );

  modport slave (
    input  i_btnsig,
    output o_press, o_release, o_short_press, o_long_press, o_repeat, o_held
  );
endinterface

// File: rtl/button_event_decoder.sv
// Re-qualifies a synchronized button level and turns it into press/release,
// short/long classification and auto-repeat pulses. All outputs are registered.
module button_event_decoder #(
  parameter int unsigned STABLE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES   = 100_000_000,
  parameter int unsigned REPEAT_CYCLES = 20_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  button_event_decoder_if.slave  btn_if
);
  localparam int unsigned QW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
  localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [QW-1:0] QUAL_LAST = QW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_QUAL,
    S_HELD,
    S_LONG_HELD,
    S_REL_QUAL
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [QW-1:0] r_qual, w_qual_nxt;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic [RW-1:0] r_rep, w_rep_nxt;
  logic          r_from_long, w_from_long_nxt;
  logic          r_press, r_release, r_short, r_long, r_repeat, r_held;
  logic          w_press_nxt, w_release_nxt, w_short_nxt, w_long_nxt, w_repeat_nxt, w_held_nxt;
  logic          w_btn;

  assign w_btn = btn_if.i_btnsig;

  always_comb begin
    w_state_nxt     = r_state;
    w_qual_nxt      = r_qual;
    w_hold_nxt      = r_hold;
    w_rep_nxt       = r_rep;
    w_from_long_nxt = r_from_long;
    w_press_nxt     = 1'b0;
    w_release_nxt   = 1'b0;
    w_short_nxt     = 1'b0;
    w_long_nxt      = 1'b0;
    w_repeat_nxt    = 1'b0;
    w_held_nxt      = r_held;
    unique case (r_state)
      S_IDLE: begin
        w_qual_nxt = '0;
        if (w_btn) begin
          w_state_nxt = S_PRESS_QUAL;
          w_qual_nxt  = QW'(1);
        end
      end
      S_PRESS_QUAL: begin
        if (!w_btn) begin
          w_state_nxt = S_IDLE;
          w_qual_nxt  = '0;
        end else if (r_qual == QUAL_LAST) begin
          w_state_nxt = S_HELD;
          w_qual_nxt  = '0;
          w_hold_nxt  = '0;
          w_press_nxt = 1'b1;
          w_held_nxt  = 1'b1;
        end else begin
          w_qual_nxt = r_qual + 1'b1;
        end
      end
      S_HELD, S_LONG_HELD, S_REL_QUAL: begin
        if (!w_btn && r_state != S_REL_QUAL) begin
          // A 0 sample outranks a long_press that would fire on this edge.
          w_state_nxt     = S_REL_QUAL;
          w_qual_nxt      = QW'(1);
          w_from_long_nxt = (r_state == S_LONG_HELD);
        end else if (!w_btn) begin
          if (r_qual == QUAL_LAST) begin
            w_state_nxt   = S_IDLE;
            w_qual_nxt    = '0;
            w_release_nxt = 1'b1;
            w_short_nxt   = !r_from_long;
            w_held_nxt    = 1'b0;
          end else begin
            w_qual_nxt = r_qual + 1'b1;
          end
        end else begin
          // A 1 sample (including one ending a dip) counts as a cycle of the
          // hold phase, so a dip delays long/repeat by exactly its REL_QUAL cycles.
          w_qual_nxt = '0;
          if (r_state == S_LONG_HELD || (r_state == S_REL_QUAL && r_from_long)) begin
            w_state_nxt = S_LONG_HELD;
            if (r_rep == REP_LAST) begin
              w_rep_nxt    = '0;
              w_repeat_nxt = 1'b1;
            end else begin
              w_rep_nxt = r_rep + 1'b1;
            end
          end else if (r_hold == HOLD_LAST) begin
            w_state_nxt = S_LONG_HELD;
            w_hold_nxt  = '0;
            w_rep_nxt   = '0;
            w_long_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_HELD;
            w_hold_nxt  = r_hold + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_qual_nxt  = '0;
        w_held_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_qual      <= '0;
      r_hold      <= '0;
      r_rep       <= '0;
      r_from_long <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_short     <= 1'b0;
      r_long      <= 1'b0;
      r_repeat    <= 1'b0;
      r_held      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_qual      <= w_qual_nxt;
      r_hold      <= w_hold_nxt;
      r_rep       <= w_rep_nxt;
      r_from_long <= w_from_long_nxt;
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
      r_short     <= w_short_nxt;
      r_long      <= w_long_nxt;
      r_repeat    <= w_repeat_nxt;
      r_held      <= w_held_nxt;
    end
  end

  assign btn_if.o_press       = r_press;
  assign btn_if.o_release     = r_release;
  assign btn_if.o_short_press = r_short;
  assign btn_if.o_long_press  = r_long;
  assign btn_if.o_repeat      = r_repeat;
  assign btn_if.o_held        = r_held;
endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with STABLE=4, LONG=20, REPEAT=8.
module tb_button_event_decoder;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  button_event_decoder_if bif ();

  button_event_decoder #(
    .STABLE_CYCLES(4),
    .LONG_CYCLES  (20),
    .REPEAT_CYCLES(8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn_if(bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observed vector order: press, release, short_press, long_press, repeat, held
  function automatic logic [5:0] obs();
    return {bif.o_press, bif.o_release, bif.o_short_press,
            bif.o_long_press, bif.o_repeat, bif.o_held};
  endfunction

  // Drive one cycle's inputs, then sample just after the edge that consumes them.
  task automatic tick(input logic b, input logic r);
    bif.i_btnsig = b;
    rst          = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    logic [5:0] got;
    do_reset();
    got = obs();
    n_checks++;
    if (got !== 6'b0) $display("FAIL reset_state got=%b exp=%b", got, 6'b0);
    else n_pass++;
    for (int t = 0; t < 6; t++) begin
      tick(1'b1, 1'b1);
      got = obs();
      n_checks++;
      if (got !== 6'b0) $display("FAIL reset_priority t=%0d got=%b exp=%b", t, got, 6'b0);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [5:0] got;
    logic [7:0] pat;
    pat = 8'b1110_1100;
    do_reset();
    for (int t = 0; t < 16; t++) begin
      tick((t < 8) ? pat[7 - t] : 1'b0, 1'b0);
      got = obs();
      n_checks++;
      if (got !== 6'b0) $display("FAIL bounce cyc=%0d got=%b exp=%b", t + 1, got, 6'b0);
      else n_pass++;
    end
  endtask

  task automatic test_short_press();
    logic [5:0] got, exp;
    int c;
    do_reset();
    for (int t = 0; t < 32; t++) begin
      tick(t < 12, 1'b0);
      c   = t + 1;
      exp = {c == 4, c == 16, c == 16, 1'b0, 1'b0, (c >= 4 && c < 16)};
      got = obs();
      n_checks++;
      if (got !== exp) $display("FAIL short_press cyc=%0d got=%b exp=%b", c, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_long_hold();
    logic [5:0] got, exp;
    int c;
    do_reset();
    for (int t = 0; t < 64; t++) begin
      tick(t < 50, 1'b0);
      c   = t + 1;
      exp = {c == 4, c == 54, 1'b0, c == 24, (c == 32 || c == 40 || c == 48),
             (c >= 4 && c < 54)};
      got = obs();
      n_checks++;
      if (got !== exp) $display("FAIL long_hold cyc=%0d got=%b exp=%b", c, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_release_glitch();
    logic [5:0] got, exp;
    int c;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      tick((t < 30) && (t != 9) && (t != 10), 1'b0);
      c   = t + 1;
      exp = {c == 4, c == 34, 1'b0, c == 26, 1'b0, (c >= 4 && c < 34)};
      got = obs();
      n_checks++;
      if (got !== exp) $display("FAIL release_glitch cyc=%0d got=%b exp=%b", c, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [5:0] got, exp;
    int c;
    do_reset();
    for (int t = 0; t < 30; t++) begin
      tick(1'b1, t == 14);
      c   = t + 1;
      exp = {(c == 4 || c == 19), 1'b0, 1'b0, 1'b0, 1'b0,
             ((c >= 4 && c <= 14) || c >= 19)};
      got = obs();
      n_checks++;
      if (got !== exp) $display("FAIL reset_mid_hold cyc=%0d got=%b exp=%b", c, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_long_vs_release();
    logic [5:0] got, exp;
    int c;
    do_reset();
    for (int t = 0; t < 36; t++) begin
      tick(t < 23, 1'b0);
      c   = t + 1;
      exp = {c == 4, c == 27, c == 27, 1'b0, 1'b0, (c >= 4 && c < 27)};
      got = obs();
      n_checks++;
      if (got !== exp) $display("FAIL long_vs_release cyc=%0d got=%b exp=%b", c, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] got, exp;
    int c;
    do_reset();
    // Two short presses separated by exactly the release qualification time.
    for (int t = 0; t < 40; t++) begin
      tick((t < 6) || (t >= 10 && t < 16), 1'b0);
      c   = t + 1;
      exp = {(c == 4 || c == 14), (c == 10 || c == 20), (c == 10 || c == 20),
             1'b0, 1'b0, ((c >= 4 && c < 10) || (c >= 14 && c < 20))};
      got = obs();
      n_checks++;
      if (got !== exp) $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, got, exp);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    rst          = 1'b1;
    bif.i_btnsig = 1'b0;
    test_reset();
    test_bounce();
    test_short_press();
    test_long_hold();
    test_release_glitch();
    test_reset_mid_hold();
    test_long_vs_release();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Converts the synchronized button level from the debouncer (`btnsig`) into discrete user-interface events for the watch control logic. It re-qualifies the level over a programmable stable window, then emits single-cycle press and release events. It also classifies each hold as short or long and generates auto-repeat ticks while a long hold continues. It sits between each button's debouncer and the mode/time-set state machine; one instance is used per button.

## Interface
- `STABLE_CYCLES`, default 1_000_000: consecutive identical samples required to accept a level change (10 ms at 100 MHz); minimum 2.
- `LONG_CYCLES`, default 100_000_000: held-state cycles, counted from the press event, before `long_press` fires (1 s); minimum 2.
- `REPEAT_CYCLES`, default 20_000_000: interval between `repeat` pulses after `long_press` (200 ms); minimum 2.

Ports:
- `clk`, input, 1: system clock; the single clock domain of the block.
- `rst`, input, 1: reset; synchronous, active-high.
- `btnsig`, input, 1: button level, already synchronized to `clk`.
- `press`, output, 1: one-cycle pulse when a press is accepted.
- `release`, output, 1: one-cycle pulse when a release is accepted.
- `short_press`, output, 1: one-cycle pulse coincident with `release` when `long_press` did not fire during this hold.
- `long_press`, output, 1: one-cycle pulse, at most once per hold.
- `repeat`, output, 1: one-cycle pulse every `REPEAT_CYCLES` after `long_press` while the button stays held.
- `held`, output, 1: level; high while a press is accepted and not yet released.

## Operation
- All outputs are registered.
- State machine:
  - IDLE: qualification counter is 0. `btnsig`=1 moves to PRESS_QUAL.
  - PRESS_QUAL: counts consecutive 1 samples. Any 0 sample returns to IDLE and clears the counter. On the `STABLE_CYCLES`-th consecutive 1 sample, moves to HELD; in the same edge, `press`=1 and `held`=1 are set and the hold counter is cleared.
  - HELD (long not yet fired): the hold counter increments every cycle. When it reaches `LONG_CYCLES`, moves to LONG_HELD; in the same edge `long_press`=1 is set and the repeat counter is cleared. A 0 sample moves to REL_QUAL.
  - LONG_HELD: the repeat counter increments every cycle. When it reaches `REPEAT_CYCLES`, `repeat`=1 is set and the counter restarts. A 0 sample moves to REL_QUAL.
  - REL_QUAL: counts consecutive 0 samples. Hold and repeat counters are frozen; no `long_press` or `repeat` is issued. A 1 sample returns to the originating state (HELD or LONG_HELD) with counters intact. On the `STABLE_CYCLES`-th consecutive 0 sample, moves to IDLE; in the same edge `release`=1 is set, `held`=0 is set, and `short_press`=1 is set if the origin was HELD.
- Counter widths are `$clog2(param+1)`. No counter wraps; each is cleared on a state transition.
- If the hold counter reaches `LONG_CYCLES` in the same cycle that a 0 sample arrives, the 0 sample takes priority: the block enters REL_QUAL and `long_press` is not issued.
- `press` and `release` never assert in the same cycle. No event fires twice from a single edge.

## Timing
- All outputs are 0 after reset. State is IDLE and all counters are 0.
- Latency from the first qualifying sample (edge E) to the corresponding output:
  - `press`: visible in the cycle after edge E+`STABLE_CYCLES`-1.
  - `release` and `short_press`: same latency, measured from the first 0 sample.
- `long_press` appears `LONG_CYCLES` cycles after `press`, plus any cycles spent in REL_QUAL.
- `repeat` appears every `REPEAT_CYCLES` cycles after `long_press`, plus any cycles spent in REL_QUAL.
- Reset mid-operation: the block returns to IDLE immediately. No `release` or `short_press` is emitted for the aborted hold. If `btnsig` is still 1 after reset, a full qualification occurs and a fresh `press` is emitted.
- `rst` has priority over all inputs in the same cycle.

## Test plan
All scenarios use `STABLE_CYCLES`=4, `LONG_CYCLES`=20, `REPEAT_CYCLES`=8. Cycle P is the cycle in which `press` is visible.

1. Bounce: `btnsig` pattern 1,1,1,0,1,1,0 then 0 -> no output ever asserts and `held` stays 0.
2. Short press: `btnsig` high from cycle 0 for 12 cycles, then low:
   - `press` pulses in cycle 4; `held`=1 from cycle 4.
   - `release` and `short_press` pulse together in cycle 16; `held`=0 from cycle 16.
   - `long_press` never asserts.
3. Long hold of 50 cycles:
   - `long_press` at P+20.
   - `repeat` at P+28, P+36, P+44.
   - On release, `release` pulses and `short_press` stays 0.
4. Release glitch: 2-cycle low dip at P+5 -> no `release`; `held` stays 1; `long_press` moves to P+22.
5. Reset at P+10 with `btnsig` held high:
   - All outputs are 0 the next cycle, with no `release` or `short_press`.
   - After `rst` deasserts, a new `press` follows 4 high samples later.
6. Simultaneous long and release: the first 0 sample coincides with the hold counter reaching 20 -> no `long_press`; `short_press` and `release` pulse after 4 low samples.
